seg_display_ctrl: RTL

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

---
 rtl/seg_display_if.sv | 20 ++
 rtl/seg_display_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/seg_display_if.sv
// Requester handshake bundle for seg_display_ctrl: two level requests with
// their display words and the one-cycle grant pulses returned to them.
interface seg_display_if;
  logic        req_a;
  logic        req_b;
  logic [11:0] val_a;
  logic [11:0] val_b;
  logic        ack_a;
  logic        ack_b;

  modport master (
    output req_a, req_b, val_a, val_b,
    input  ack_a, ack_b
  );

  modport slave (
    input  req_a, req_b, val_a, val_b,
    output ack_a, ack_b
  );
endinterface

// File: rtl/seg_display_ctrl.sv
// Six-digit 7-segment display controller: round-robin grant of two requesters
// with a minimum hold time, plus multiplexed digit scanning.
// Optional macro SEG_ERR_BLINK_EN blinks the display while val_out is in error mode.
module seg_display_ctrl #(
  parameter int unsigned SCAN_DIV   = 16,
  parameter int unsigned HOLD_CYC   = 1024,
  parameter int unsigned BLINK_LOG2 = 12
) (
  input  logic              clk,
  input  logic              rst,
  seg_display_if.slave      req_if,
  output logic [11:0]       val_out,
  input  logic [23:0]       bcd_in,
  output logic [5:0]        digit_en,
  output logic [3:0]        cur_bcd
);

  if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_bad_scan_div
    $error("SCAN_DIV out of range");
  end
  if (HOLD_CYC < 2 || HOLD_CYC > 65535) begin : g_bad_hold_cyc
    $error("HOLD_CYC out of range");
  end
  if (BLINK_LOG2 < 1 || BLINK_LOG2 > 30) begin : g_bad_blink_log2
    $error("BLINK_LOG2 out of range");
  end

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        last_b;
  logic        grant_a, grant_b;

  logic [15:0] scan_q;
  logic [2:0]  digit_idx;
  logic [3:0]  sel_code;
  logic        blank_sel;

  // Arbitration: round robin on ties, requests ignored while holding.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_if.req_a && (!req_if.req_b || last_b)) begin
          grant_a = 1'b1;
        end else if (req_if.req_b) begin
          grant_b = 1'b1;
        end
        if (grant_a || grant_b) begin
          state_d = HOLD;
          hold_d  = 16'(HOLD_CYC - 1);
        end
      end
      HOLD: begin
        if (hold_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= 16'd0;
      last_b       <= 1'b1;
      val_out      <= 12'h800;
      req_if.ack_a <= 1'b0;
      req_if.ack_b <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      req_if.ack_a <= grant_a;
      req_if.ack_b <= grant_b;
      if (grant_a) begin
        val_out <= req_if.val_a;
        last_b  <= 1'b0;
      end else if (grant_b) begin
        val_out <= req_if.val_b;
        last_b  <= 1'b1;
      end
    end
  end

  // Digit scan: index advances once per SCAN_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q    <= 16'd0;
      digit_idx <= 3'd0;
    end else if (scan_q == 16'(SCAN_DIV - 1)) begin
      scan_q    <= 16'd0;
      digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
    end else begin
      scan_q <= scan_q + 16'd1;
    end
  end

  assign sel_code = bcd_in[{digit_idx, 2'b00} +: 4];

`ifdef SEG_ERR_BLINK_EN
  logic [BLINK_LOG2:0] blink_q;
  logic                blink_off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_q + 1'b1;
    end
  end

  // Top bit toggles every 2^BLINK_LOG2 cycles, giving the dark/lit windows.
  assign blink_off = (val_out[11:10] == 2'b11) && blink_q[BLINK_LOG2];
  assign blank_sel = (sel_code == 4'd11) || blink_off;
`else
  assign blank_sel = (sel_code == 4'd11);
`endif

  // Output register: select lines and code lag the index by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_en <= 6'b000000;
      cur_bcd  <= 4'd0;
    end else begin
      digit_en <= blank_sel ? 6'b000000 : (6'b000001 << digit_idx);
      cur_bcd  <= sel_code;
    end
  end

endmodule
